// File: rtl/quat_mult_seq.sv
// quat_mult_seq -- sequential Hamilton product of two Q2.14 quaternions.
//
// The first frame (rising edge of data_ready) is captured as A and the second
// as B. The product A*B is then formed with one shared 16x16 multiplier, one
// term per cycle over 16 cycles. The result is presented in DONE with a
// res_valid/res_ready handshake.
//
// Ports:
//   sclk, rst        clock, synchronous active-high reset
//   q0..q3           incoming quaternion components, signed Q2.14
//   data_ready       frame strobe; only its rising edge matters
//   res_ready        consumer accepts the result (looked at only in DONE)
//   p0..p3           result components, signed Q2.14, saturated
//   res_valid        p0..p3 hold a finished result
//   busy             high in CALC and DONE
//   ovf              a component of the current result saturated
//   overrun          sticky: a frame arrived while it could not be accepted

module quat_mult_seq (
    input  logic        sclk,
    input  logic        rst,
    input  logic [15:0] q0,
    input  logic [15:0] q1,
    input  logic [15:0] q2,
    input  logic [15:0] q3,
    input  logic        data_ready,
    input  logic        res_ready,
    output logic [15:0] p0,
    output logic [15:0] p1,
    output logic [15:0] p2,
    output logic [15:0] p3,
    output logic        res_valid,
    output logic        busy,
    output logic        ovf,
    output logic        overrun
);

    typedef enum logic [1:0] {WAIT_A, WAIT_B, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic               dr_prev;
    logic               rise;
    logic [3:0][15:0]   a, b;
    logic [3:0]         k;
    logic signed [33:0] acc;

    logic [1:0]         comp, trm;
    logic signed [15:0] mul_a, mul_b;
    logic signed [31:0] prod;
    logic signed [33:0] prod_x, term, s, rnd, shr;
    logic               neg;
    logic               sat;
    logic [15:0]        res16;

    assign rise = data_ready & ~dr_prev;
    assign busy = (state == CALC) || (state == DONE);

    // k[3:2] picks the output component, k[1:0] the term. Term t of every
    // component uses a[t]; the matching b index works out to comp ^ t.
    assign comp  = k[3:2];
    assign trm   = k[1:0];
    assign mul_a = a[trm];
    assign mul_b = b[comp ^ trm];
    assign prod  = mul_a * mul_b;

    // Negative terms: p0 t1..t3, p1 t3, p2 t1, p3 t2.
    always_comb begin
        neg = 1'b0;
        case (k)
            4'd1, 4'd2, 4'd3, 4'd7, 4'd9, 4'd14: neg = 1'b1;
            default:                             neg = 1'b0;
        endcase
    end

    // 34 bits hold four full-scale products (|sum| <= 2^32) without wrap.
    assign prod_x = {{2{prod[31]}}, prod};
    assign term   = neg ? -prod_x : prod_x;
    assign s      = acc + term;
    assign rnd    = s + 34'sd8192;
    assign shr    = rnd >>> 14;

    always_comb begin
        sat   = 1'b0;
        res16 = shr[15:0];
        if (shr > 34'sd32767) begin
            sat   = 1'b1;
            res16 = 16'h7FFF;
        end else if (shr < -34'sd32768) begin
            sat   = 1'b1;
            res16 = 16'h8000;
        end
    end

    // State register
    always_ff @(posedge sclk) begin
        if (rst) state <= WAIT_A;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_A: if (rise) state_nxt = WAIT_B;
            WAIT_B: if (rise) state_nxt = CALC;
            CALC:   if (k == 4'd15) state_nxt = DONE;
            DONE:   if (res_ready) state_nxt = rise ? WAIT_B : WAIT_A;
            default: state_nxt = WAIT_A;
        endcase
    end

    // Datapath and flags
    always_ff @(posedge sclk) begin
        if (rst) begin
            dr_prev   <= 1'b0;
            a         <= '0;
            b         <= '0;
            k         <= '0;
            acc       <= '0;
            p0        <= '0;
            p1        <= '0;
            p2        <= '0;
            p3        <= '0;
            res_valid <= 1'b0;
            ovf       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            dr_prev <= data_ready;
            case (state)
                WAIT_A: begin
                    if (rise) a <= {q3, q2, q1, q0};
                end
                WAIT_B: begin
                    if (rise) begin
                        b   <= {q3, q2, q1, q0};
                        k   <= '0;
                        acc <= '0;
                        ovf <= 1'b0;
                    end
                end
                CALC: begin
                    if (rise) overrun <= 1'b1;
                    k <= k + 4'd1;
                    if (trm == 2'd3) begin
                        acc <= '0;
                        if (sat) ovf <= 1'b1;
                        case (comp)
                            2'd0:    p0 <= res16;
                            2'd1:    p1 <= res16;
                            2'd2:    p2 <= res16;
                            default: p3 <= res16;
                        endcase
                    end else begin
                        acc <= s;
                    end
                    if (k == 4'd15) res_valid <= 1'b1;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        // Handshake and a new frame on the same edge: the
                        // frame is taken as the next A.
                        if (rise) a <= {q3, q2, q1, q0};
                    end else if (rise) begin
                        overrun <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/quat_mult_seq.md
QUAT_MULT_SEQ -- requirements
Module: quat_mult_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: sclk input 1, rst input 1.
REQ-002 Port q0, q1, q2, q3: input, 16 bits each; signed Q2.14 quaternion components (0x4000 = +1.0) from the SPI receive stage.
REQ-003 Port data_ready: input, 1 bit; a frame is valid on the cycle this signal rises; it may stay high for several cycles.
REQ-004 Port res_ready: input, 1 bit; the consumer accepts the result.
REQ-005 Ports p0, p1, p2, p3: output reg, 16 bits each; signed Q2.14 Hamilton product A*B.
REQ-006 Port res_valid: output reg, 1 bit; the result on p0..p3 is valid.
REQ-007 Port busy: output, 1 bit; high in CALC and DONE.
REQ-008 Port ovf: output reg, 1 bit; at least one component of the current result saturated.
REQ-009 Port overrun: output reg, 1 bit; sticky flag; a frame was dropped.

Function
REQ-010 The block SHALL detect frames by rising edge only: rise = data_ready & ~dr_prev, where dr_prev is a register.
REQ-011 The state machine SHALL have four states: WAIT_A, WAIT_B, CALC, DONE.
REQ-012 WAIT_A: on rise, capture q0..q3 into a0..a3 and go to WAIT_B.
REQ-013 WAIT_B: on rise, capture q0..q3 into b0..b3, clear the term counter k and the accumulator, and go to CALC.
REQ-014 CALC SHALL use exactly one 16x16 signed multiplier and form one product term per cycle, 16 cycles total (k = 0..15). Component index is k[3:2]; term index is k[1:0].
REQ-015 The term order and signs SHALL be:
  - p0 = +a0b0 -a1b1 -a2b2 -a3b3
  - p1 = +a0b1 +a1b0 +a2b3 -a3b2
  - p2 = +a0b2 -a1b3 +a2b0 +a3b1
  - p3 = +a0b3 +a1b2 -a2b1 +a3b0
REQ-016 Arithmetic: each product is a 32-bit signed value; the accumulator is 34-bit signed; no intermediate wrap is allowed.
REQ-017 On each term-3 cycle, the block SHALL form s = acc + term, add 8192, shift right arithmetically by 14, and saturate to [-32768, 32767]. It SHALL write the result to p[k[3:2]] and clear the accumulator.
REQ-018 If any saturation occurs in a calculation, ovf SHALL be 1. ovf is cleared when CALC is entered.
REQ-019 On the k = 15 edge, the block SHALL set res_valid = 1 and go to DONE.
REQ-020 Latency: res_valid SHALL rise on the 16th rising edge after the B-capture edge.
REQ-021 p0..p3 SHALL change only in CALC. During CALC, p0..p3 may hold a mix of old and new components; res_valid is 0 then.
REQ-022 DONE: p0..p3, ovf and res_valid SHALL be held stable while res_ready = 0.
REQ-023 DONE: on an edge with res_ready = 1, res_valid SHALL go to 0 and the state SHALL go to WAIT_A.
REQ-024 A rise in CALC SHALL drop the frame and set overrun = 1.
REQ-025 A rise in DONE with res_ready = 0 SHALL drop the frame and set overrun = 1.
REQ-026 A rise in DONE with res_ready = 1 on the same edge SHALL complete the handshake, capture the frame as A, and go to WAIT_B.
REQ-027 res_ready SHALL be ignored outside DONE.
REQ-028 Operands a and b SHALL remain unchanged from capture until the next capture.

Reset
REQ-029 On an rst edge, the state SHALL go to WAIT_A.
REQ-030 On an rst edge, p0..p3, a, b, acc, k, res_valid, ovf, overrun and dr_prev SHALL all be 0.
REQ-031 rst SHALL take priority over every other input in every state. A reset mid-CALC or in DONE aborts the operation and discards partial results.
REQ-032 If data_ready is high during the first cycle after reset, that cycle SHALL count as a rising edge (dr_prev = 0).

Verification
REQ-033 Identity: A = (0x4000,0,0,0), B = (0x2000,0x1000,0xF000,0x0800) -> p = (0x2000,0x1000,0xF000,0x0800), ovf = 0, res_valid on the 16th edge after B capture.
REQ-034 Basis products: i*i with A = B = (0,0x4000,0,0) -> p = (0xC000,0,0,0); i*j with A = (0,0x4000,0,0), B = (0,0,0x4000,0) -> p = (0,0,0,0x4000).
REQ-035 Saturation: A = B = (0x7FFF,0,0,0) -> p0 = 0x7FFF, ovf = 1; the next normal product -> ovf = 0.
REQ-036 Backpressure: hold res_ready = 0 for 10 cycles in DONE and send a third frame -> p and res_valid are stable, overrun = 1, the frame is not captured. Then res_ready = 1 -> state WAIT_A.
REQ-037 Same-edge rise and res_ready in DONE -> the new frame becomes A, state WAIT_B, overrun unchanged.
REQ-038 Mid-CALC rst at k = 7 -> all outputs 0 and state WAIT_A on the next cycle. A subsequent A/B pair produces the correct result.
